// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: shared state type, line geometry and lowest-set-bit helper
//   for decoder_scan_ctrl and scan_next_sel.
package decoder_scan_pkg;
    localparam int NUM_LINES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {IDLE, BLANK, DWELL} scan_state_t;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_LINES-1:0] m);
        lowest_set = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--)
            if (m[i]) lowest_set = SEL_W'(i);
    endfunction
endpackage

// File: rtl/scan_next_sel.sv
// scan_next_sel: rotating-priority finder for the next enabled decoder line.
//   mask : line-enable mask
//   cur  : currently selected line
//   next : lowest set mask bit strictly above cur, else lowest set bit overall
//   wrap : no set bit above cur, so the search wrapped around
//   none : mask is empty
module scan_next_sel
    import decoder_scan_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [SEL_W-1:0]     cur,
    output logic [SEL_W-1:0]     next,
    output logic                 wrap,
    output logic                 none
);
    logic [SEL_W-1:0] above;
    logic             hit;

    // Descending scan so the lowest qualifying bit is the last one written.
    always_comb begin
        above = '0;
        hit   = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask[i] && i > int'(cur)) begin
                above = SEL_W'(i);
                hit   = 1'b1;
            end
        end
    end

    assign next = hit ? above : lowest_set(mask);
    assign wrap = !hit;
    assign none = mask == '0;
endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: steps a 3-to-8 decoder through its enabled lines with
//   programmable dwell and a fixed blanking gap before each line.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a scan (ignored while busy or with an empty mask)
//   stop      : abort the scan; wins over start
//   single    : latched on start, 1 = one pass then idle
//   dwell     : active cycles per line (0 acts as 1), sampled entering DWELL
//   mask      : live line-enable mask
//   sel_out   : decoder select, en_out : decoder enable (both registered)
//   busy      : scan in progress, pass_done : pulse after a pass completes
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel_out,
    output logic               en_out,
    output logic               busy,
    output logic               pass_done
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    scan_state_t      state, state_nxt;
    logic [BW-1:0]      bcnt, bcnt_nxt;
    logic [DWELL_W-1:0] dcnt, dcnt_nxt;
    logic               single_q, single_nxt;
    logic [SEL_W-1:0]   sel_nxt, nsel;
    logic               en_nxt, busy_nxt, pd_nxt;
    logic               wrap, none;
    logic               start_ok, blank_end, dwell_end, pass_end;

    scan_next_sel u_next (
        .mask (mask),
        .cur  (sel_out),
        .next (nsel),
        .wrap (wrap),
        .none (none)
    );

    assign start_ok  = state == IDLE && start && !stop && mask != '0;
    assign blank_end = state == BLANK && bcnt == BW'(BLANK_CYCLES - 1);
    assign dwell_end = state == DWELL && dcnt == '0;
    assign pass_end  = dwell_end && (wrap || none);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bcnt      <= '0;
            dcnt      <= '0;
            single_q  <= 1'b0;
            sel_out   <= '0;
            en_out    <= 1'b0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcnt      <= bcnt_nxt;
            dcnt      <= dcnt_nxt;
            single_q  <= single_nxt;
            sel_out   <= sel_nxt;
            en_out    <= en_nxt;
            busy      <= busy_nxt;
            pass_done <= pd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start_ok ? BLANK : IDLE;
            BLANK:   state_nxt = stop ? IDLE : blank_end ? DWELL : BLANK;
            DWELL:   state_nxt = stop ? IDLE :
                                 !dwell_end ? DWELL :
                                 (pass_end && (single_q || none)) ? IDLE : BLANK;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    // sel_out only moves on start or on the DWELL->BLANK hop, never while enabled.
    always_comb begin
        sel_nxt    = start_ok ? lowest_set(mask) :
                     (dwell_end && state_nxt == BLANK) ? nsel : sel_out;
        en_nxt     = state_nxt == DWELL;
        busy_nxt   = state_nxt != IDLE;
        pd_nxt     = pass_end && !stop;
        single_nxt = start_ok ? single : single_q;
        bcnt_nxt   = (state == BLANK && !blank_end) ? bcnt + BW'(1) : '0;
        dcnt_nxt   = (state_nxt == DWELL && state != DWELL) ?
                         ((dwell == '0) ? '0 : dwell - DWELL_W'(1)) :
                     (state == DWELL && dcnt != '0) ? dcnt - DWELL_W'(1) : dcnt;
    end
endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer that drives the select and enable inputs of the 3-to-8 decoder, stepping through the enabled output lines in ascending order. Each selected line is held active for a programmable dwell time, with a fixed blanking gap between lines so the decoder select settles while its enable is low. It sits directly upstream of `decoder_3to8`: `sel_out` drives `in`, and `en_out` drives `en`.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `BLANK_CYCLES`, default 2, minimum 1: number of cycles `en_out` stays low before each line becomes active.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request to begin a scan; level sampled each cycle.
- `stop`  in  1: abort request; level sampled each cycle.
- `single`  in  1: 1 = run one pass then stop; 0 = repeat passes continuously. Sampled on `start`.
- `dwell`  in  DWELL_W: active cycles per line. Sampled on entry to each DWELL phase.
- `mask`  in  8: line-enable mask; bit i set means line i is scanned. Read live.
- `sel_out`  out  3: decoder select, registered.
- `en_out`  out  1: decoder enable, registered.
- `busy`  out  1: high while the scan is not IDLE.
- `pass_done`  out  1: one-cycle pulse after the last enabled line of a pass finishes.

## Operation
- Reset values: `sel_out`=0, `en_out`=0, `busy`=0, `pass_done`=0, state IDLE.
- The FSM has three states: IDLE, BLANK, DWELL.
- **IDLE**
  - If `start`=1 and `mask`≠0: latch `single`, set `sel_out` to the lowest set bit of `mask`, set `busy`=1, go to BLANK.
  - If `start`=1 and `mask`=0: the start is ignored.
- **BLANK**
  - `en_out`=0 for exactly BLANK_CYCLES cycles, then go to DWELL.
  - `sel_out` is stable throughout BLANK.
- **DWELL**
  - `en_out`=1 for `dwell` cycles. `dwell`=0 is treated as 1.
  - In the last DWELL cycle, compute the next line: the lowest set bit of the current `mask` strictly above `sel_out`, wrapping to the lowest set bit overall.
  - If a wrap occurs, or `mask`=0, the pass is complete and `pass_done` pulses in the next cycle.
  - Pass complete and (`single` latched, or `mask`=0): go to IDLE, `en_out`=0, `busy`=0, `sel_out` holds.
  - Otherwise: load `sel_out` with the next line and go to BLANK.
- **stop**
  - From BLANK or DWELL: go to IDLE on the next edge. `en_out`=0, `busy`=0, `sel_out` holds, no `pass_done`.
- **Simultaneous events**
  - `start` and `stop` in the same cycle in IDLE: stop wins and the scan stays IDLE.
  - `start` while busy is ignored.
- **Live mask**
  - Clearing the current line's mask bit mid-DWELL does not shorten that dwell; the bit only affects the next-line computation.
  - A mask with a single set bit gives `pass_done` at the end of every dwell.
- Reset mid-scan: all outputs return to reset values immediately, asynchronously.

## Timing
- `start` sampled at edge 0. At edge 1, `busy`=1, `sel_out` is valid and `en_out`=0.
- `en_out` rises at edge 1+BLANK_CYCLES and stays high for max(`dwell`,1) cycles.
- Period per line = BLANK_CYCLES + max(`dwell`,1) cycles.
- `pass_done` is high for the single cycle after the final DWELL cycle of a pass, coincident with the first BLANK cycle of the next pass or with IDLE.
- `sel_out` never changes while `en_out`=1, so there are no glitches on the decoder output.
- `stop` to `en_out`=0 takes one cycle.

## Structure
- Package `decoder_scan_pkg` holds:
  - the state enum `scan_state_t` {IDLE, BLANK, DWELL};
  - `NUM_LINES`=8 and `SEL_W`=3.
- Sub-module `scan_next_sel`: combinational rotating-priority finder.
  - Inputs: `mask[7:0]` and `cur[2:0]`.
  - Outputs: `next[2:0]`, `wrap`, `none`.
- Top level holds the FSM, the dwell counter (DWELL_W bits) and the blank counter (clog2(BLANK_CYCLES+1) bits).

## Test plan
- Reset; `mask`=8'hFF, `dwell`=3, `single`=1, pulse `start`:
  - `sel_out` steps 0..7;
  - each line shows 2 cycles `en_out`=0 then 3 cycles `en_out`=1;
  - one `pass_done` pulse; `busy` falls after 40 cycles.
- `mask`=8'b1010_0100, `dwell`=1, `single`=0:
  - `sel_out` sequence 2,5,7,2,5,7…;
  - `pass_done` after each line-7 dwell;
  - `stop` mid-DWELL gives `en_out`=0 next cycle and `sel_out` held.
- `mask`=0 with `start`: `busy` stays 0 and `en_out` stays 0. `dwell`=0 with `mask`=8'h01: `en_out` high for 1 cycle.
- `start`=`stop`=1 in IDLE: no scan. `start` pulsed while busy: sequence unaffected.
- Clear `mask` to 0 during a line-3 DWELL:
  - the dwell completes;
  - `pass_done` pulses and the FSM goes to IDLE.
- Assert `rst` mid-DWELL:
  - `en_out`, `busy` and `sel_out` go to 0 without waiting for a clock edge;
  - after release, a new `start` begins from the lowest mask bit.
- Checker throughout: with `decoder_3to8` instantiated downstream, its `out` is one-hot on `sel_out` exactly when `en_out`=1, and `sel_out` is never seen to change while `en_out`=1.
